// File: rtl/mem_request_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: AXI field widths,
// arbitration modes, request record and default watermark/age settings.
package MemoryController_Definitions;

  localparam int unsigned AXI_ADDRWIDTH = 32;
  localparam int unsigned AXI_IDWIDTH   = 4;
  localparam int unsigned NUM_FSM       = 4;

  localparam int unsigned WR_HIGH_WM_DEF  = 6;
  localparam int unsigned WR_LOW_WM_DEF   = 2;
  localparam int unsigned ARB_MAX_AGE_DEF = 64;

  typedef enum logic {
    READ_MODE   = 1'b0,
    WRITE_DRAIN = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic [AXI_ADDRWIDTH-1:0] addr;
    logic [AXI_IDWIDTH-1:0]   id;
  } axi_req_t;

endpackage

// File: rtl/mem_request_arbiter_req_fifo.sv
// Synchronous request FIFO with occupancy count. Full is derived from the
// registered count, so a push on a full FIFO is refused even when a pop
// happens in the same cycle.
module req_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Read/write address request arbiter in front of address translation.
// Buffers AR and AW requests, presents one head per cycle under a
// write-drain watermark FSM and pops it when the translation stage routes it.
// Optional build macro MEM_ARB_AGE_EN adds a write starvation age counter.
module mem_request_arbiter
  import MemoryController_Definitions::*;
#(
  parameter int unsigned RD_DEPTH   = 8,
  parameter int unsigned WR_DEPTH   = 8,
  parameter int unsigned WR_HIGH_WM = WR_HIGH_WM_DEF,
  parameter int unsigned WR_LOW_WM  = WR_LOW_WM_DEF,
  parameter int unsigned MAX_AGE    = ARB_MAX_AGE_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arValid,
  input  logic [AXI_ADDRWIDTH-1:0]      arAddr,
  input  logic [AXI_IDWIDTH-1:0]        arId,
  output logic                          arReady,
  input  logic                          awValid,
  input  logic [AXI_ADDRWIDTH-1:0]      awAddr,
  input  logic [AXI_IDWIDTH-1:0]        awId,
  output logic                          awReady,
  output logic                          readValid,
  output logic [AXI_ADDRWIDTH-1:0]      readAddr,
  output logic                          writeValid,
  output logic [AXI_ADDRWIDTH-1:0]      writeAddr,
  input  logic [NUM_FSM-1:0]            targetFSMVector,
  output logic                          issueValid,
  output logic                          issueIsWrite,
  output logic [AXI_IDWIDTH-1:0]        issueId,
  output logic [$clog2(RD_DEPTH):0]     rdCount,
  output logic [$clog2(WR_DEPTH):0]     wrCount,
  output logic                          drainMode
);

  localparam int unsigned RCW = $clog2(RD_DEPTH) + 1;
  localparam int unsigned WCW = $clog2(WR_DEPTH) + 1;

  // Elaboration-time sanity check of the configuration.
  if (WR_LOW_WM >= WR_HIGH_WM || WR_HIGH_WM > WR_DEPTH || MAX_AGE == 0 ||
      RD_DEPTH < 2 || WR_DEPTH < 2) begin : g_param_check
    $error("mem_request_arbiter: invalid parameter combination");
  end

  arb_mode_e       r_mode;
  arb_mode_e       w_mode_nxt;
  axi_req_t        w_ar_req;
  axi_req_t        w_aw_req;
  axi_req_t        w_rd_head;
  axi_req_t        w_wr_head;
  logic            w_rd_full;
  logic            w_wr_full;
  logic            w_ar_push;
  logic            w_aw_push;
  logic            w_rd_pop;
  logic            w_wr_pop;
  logic            w_accept;
  logic            w_force;
  logic [RCW-1:0]  w_rd_cnt_nxt;
  logic [WCW-1:0]  w_wr_cnt_nxt;

  assign w_ar_req  = '{addr: arAddr, id: arId};
  assign w_aw_req  = '{addr: awAddr, id: awId};
  assign arReady   = !w_rd_full;
  assign awReady   = !w_wr_full;
  assign w_ar_push = arValid && arReady;
  assign w_aw_push = awValid && awReady;
  assign w_accept  = |targetFSMVector;

  req_fifo #(.WIDTH($bits(axi_req_t)), .DEPTH(RD_DEPTH)) u_rd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_ar_push),
    .i_data  (w_ar_req),
    .i_pop   (w_rd_pop),
    .o_data  (w_rd_head),
    .o_count (rdCount),
    .o_full  (w_rd_full)
  );

  req_fifo #(.WIDTH($bits(axi_req_t)), .DEPTH(WR_DEPTH)) u_wr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_aw_push),
    .i_data  (w_aw_req),
    .i_pop   (w_wr_pop),
    .o_data  (w_wr_head),
    .o_count (wrCount),
    .o_full  (w_wr_full)
  );

`ifdef MEM_ARB_AGE_EN
  localparam int unsigned AGE_W = $clog2(MAX_AGE + 1);
  logic [AGE_W-1:0] r_age;

  // Forced write slot: held until that write is accepted, which clears the age.
  assign w_force = (r_age == AGE_W'(MAX_AGE));

  // Age of waiting writes while reads own the port; saturates at MAX_AGE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (r_mode == WRITE_DRAIN || w_wr_pop) begin
      r_age <= '0;
    end else if (wrCount != '0 && !w_force) begin
      r_age <= r_age + 1'b1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  assign readValid    = (r_mode == READ_MODE) && !w_force && (rdCount != '0);
  assign writeValid   = ((r_mode == WRITE_DRAIN) || w_force) && (wrCount != '0);
  assign readAddr     = w_rd_head.addr;
  assign writeAddr    = w_wr_head.addr;
  assign w_rd_pop     = readValid && w_accept;
  assign w_wr_pop     = writeValid && w_accept;
  assign issueValid   = w_rd_pop || w_wr_pop;
  assign issueIsWrite = w_wr_pop;
  assign issueId      = w_wr_pop ? w_wr_head.id : (w_rd_pop ? w_rd_head.id : '0);
  assign drainMode    = (r_mode == WRITE_DRAIN);

  assign w_rd_cnt_nxt = rdCount + RCW'(w_ar_push) - RCW'(w_rd_pop);
  assign w_wr_cnt_nxt = wrCount + WCW'(w_aw_push) - WCW'(w_wr_pop);

  // Watermark transitions, judged on occupancy after this cycle's push/pop.
  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      READ_MODE: begin
        if (w_wr_cnt_nxt >= WCW'(WR_HIGH_WM) ||
            (w_rd_cnt_nxt == '0 && w_wr_cnt_nxt != '0))
          w_mode_nxt = WRITE_DRAIN;
      end
      WRITE_DRAIN: begin
        if (w_wr_cnt_nxt == '0 ||
            (w_wr_cnt_nxt <= WCW'(WR_LOW_WM) && w_rd_cnt_nxt != '0))
          w_mode_nxt = READ_MODE;
      end
      default: w_mode_nxt = READ_MODE;
    endcase
  end

  // Arbitration mode register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mode <= READ_MODE;
    else        r_mode <= w_mode_nxt;
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Randomized self-checking bench for mem_request_arbiter against a queue-based
// reference model of the arbitration rules.
module tb_mem_request_arbiter;
  import MemoryController_Definitions::*;

  localparam int RD_D = 8;
  localparam int WR_D = 8;
  localparam int HWM  = 6;
  localparam int LWM  = 2;
  localparam int MAXA = 16;
`ifdef MEM_ARB_AGE_EN
  localparam bit AGE_EN = 1'b1;
`else
  localparam bit AGE_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     arValid = 1'b0;
  logic [AXI_ADDRWIDTH-1:0] arAddr = '0;
  logic [AXI_IDWIDTH-1:0]   arId = '0;
  logic                     arReady;
  logic                     awValid = 1'b0;
  logic [AXI_ADDRWIDTH-1:0] awAddr = '0;
  logic [AXI_IDWIDTH-1:0]   awId = '0;
  logic                     awReady;
  logic                     readValid;
  logic [AXI_ADDRWIDTH-1:0] readAddr;
  logic                     writeValid;
  logic [AXI_ADDRWIDTH-1:0] writeAddr;
  logic [NUM_FSM-1:0]       targetFSMVector = '0;
  logic                     issueValid;
  logic                     issueIsWrite;
  logic [AXI_IDWIDTH-1:0]   issueId;
  logic [3:0]               rdCount;
  logic [3:0]               wrCount;
  logic                     drainMode;

  int vectors = 0;
  int miscompares = 0;

  mem_request_arbiter #(
    .RD_DEPTH   (RD_D),
    .WR_DEPTH   (WR_D),
    .WR_HIGH_WM (HWM),
    .WR_LOW_WM  (LWM),
    .MAX_AGE    (MAXA)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .arValid         (arValid),
    .arAddr          (arAddr),
    .arId            (arId),
    .arReady         (arReady),
    .awValid         (awValid),
    .awAddr          (awAddr),
    .awId            (awId),
    .awReady         (awReady),
    .readValid       (readValid),
    .readAddr        (readAddr),
    .writeValid      (writeValid),
    .writeAddr       (writeAddr),
    .targetFSMVector (targetFSMVector),
    .issueValid      (issueValid),
    .issueIsWrite    (issueIsWrite),
    .issueId         (issueId),
    .rdCount         (rdCount),
    .wrCount         (wrCount),
    .drainMode       (drainMode)
  );

  always #5 clk = ~clk;

  // Reference model: request queues, drain flag and write age.
  axi_req_t q_rd[$];
  axi_req_t q_wr[$];
  bit       m_drain = 1'b0;
  int       m_age = 0;

  function automatic bit m_force();
    return AGE_EN && (m_age == MAXA);
  endfunction

  function automatic bit m_rv();
    return !m_drain && !m_force() && (q_rd.size() != 0);
  endfunction

  function automatic bit m_wv();
    return (m_drain || m_force()) && (q_wr.size() != 0);
  endfunction

  function automatic logic [14:0] exp_status();
    bit acc;
    acc = (targetFSMVector != '0);
    return {q_rd.size() < RD_D, q_wr.size() < WR_D, m_rv(), m_wv(),
            (m_rv() || m_wv()) && acc, m_wv() && acc, m_drain,
            4'(q_rd.size()), 4'(q_wr.size())};
  endfunction

  function automatic logic [14:0] act_status();
    return {arReady, awReady, readValid, writeValid, issueValid, issueIsWrite,
            drainMode, rdCount, wrCount};
  endfunction

  function automatic logic [67:0] exp_data();
    logic [31:0] ra, wa;
    logic [3:0]  id;
    bit acc;
    acc = (targetFSMVector != '0);
    ra = (q_rd.size() != 0) ? q_rd[0].addr : '0;
    wa = (q_wr.size() != 0) ? q_wr[0].addr : '0;
    id = '0;
    if (m_wv() && acc) id = q_wr[0].id;
    else if (m_rv() && acc) id = q_rd[0].id;
    return {ra, wa, id};
  endfunction

  function automatic logic [67:0] act_data();
    logic [31:0] ra, wa;
    logic [3:0]  id;
    bit acc;
    acc = (targetFSMVector != '0);
    ra = (q_rd.size() != 0) ? readAddr : '0;
    wa = (q_wr.size() != 0) ? writeAddr : '0;
    id = ((m_rv() || m_wv()) && acc) ? issueId : '0;
    return {ra, wa, id};
  endfunction

  task automatic drive(input bit arv, input bit awv, input logic [NUM_FSM-1:0] tgt);
    arValid = arv;
    arAddr  = $urandom;
    arId    = 4'($urandom);
    awValid = awv;
    awAddr  = $urandom;
    awId    = 4'($urandom);
    targetFSMVector = tgt;
  endtask

  // Advance the model by one clock using the inputs currently driven, then wait the edge.
  task automatic tick();
    bit rpop, wpop, rpush, wpush, acc;
    int rn, wn;
    axi_req_t e;
    acc   = (targetFSMVector != '0);
    rpop  = m_rv() && acc;
    wpop  = m_wv() && acc;
    rpush = arValid && (q_rd.size() < RD_D);
    wpush = awValid && (q_wr.size() < WR_D);
    if (AGE_EN) begin
      if (m_drain || wpop) m_age = 0;
      else if (q_wr.size() != 0 && m_age < MAXA) m_age++;
    end
    if (rpop) void'(q_rd.pop_front());
    if (wpop) void'(q_wr.pop_front());
    if (rpush) begin e.addr = arAddr; e.id = arId; q_rd.push_back(e); end
    if (wpush) begin e.addr = awAddr; e.id = awId; q_wr.push_back(e); end
    rn = q_rd.size();
    wn = q_wr.size();
    if (!m_drain) m_drain = (wn >= HWM) || (rn == 0 && wn != 0);
    else          m_drain = !((wn == 0) || (wn <= LWM && rn != 0));
    @(posedge clk);
  endtask

  task automatic model_clear();
    q_rd.delete();
    q_wr.delete();
    m_drain = 1'b0;
    m_age   = 0;
  endtask

  // Exclusivity of the two presented valids, checked every cycle.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      vectors++;
      if (readValid && writeValid) begin
        miscompares++;
        $display("FAIL valid_onehot: readValid=%b writeValid=%b, want not both 1", readValid, writeValid);
      end
    end
  end

  task automatic test_reset();
    // In reset from time 0.
    @(negedge clk); #1;
    vectors++;
    if (act_status() !== 15'b110_0000_0000_0000 || issueId !== '0) begin
      miscompares++;
      $display("FAIL reset_initial: got %b id %h want %b id 0", act_status(), issueId, 15'b110_0000_0000_0000);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(i < 3, i >= 3, '0);
      #1;
      vectors++;
      if (act_status() !== exp_status()) begin
        miscompares++;
        $display("FAIL reset_fill status: got %b want %b", act_status(), exp_status());
      end
      tick();
    end
    @(negedge clk);
    drive(1'b0, 1'b0, '0);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (act_status() !== 15'b110_0000_0000_0000 || issueId !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got %b id %h want %b id 0", act_status(), issueId, 15'b110_0000_0000_0000);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    logic [3:0] pid;
    @(negedge clk);
    drive(1'b1, 1'b0, 4'b0001);
    pid = arId;
    #1;
    vectors++;
    if (readValid !== 1'b0 || issueValid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_push_cycle: readValid=%b issueValid=%b want 0 0", readValid, issueValid);
    end
    tick();
    @(negedge clk);
    drive(1'b0, 1'b0, 4'b0001);
    #1;
    vectors++;
    if ({readValid, issueValid, issueIsWrite, issueId} !== {3'b110, pid}) begin
      miscompares++;
      $display("FAIL latency_next_cycle: got %b want %b", {readValid, issueValid, issueIsWrite, issueId}, {3'b110, pid});
    end
    vectors++;
    if (act_data() !== exp_data()) begin
      miscompares++;
      $display("FAIL latency_data: got %h want %h", act_data(), exp_data());
    end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, '0);
      #1;
      vectors++;
      if (act_status() !== exp_status()) begin
        miscompares++;
        $display("FAIL full_fill status: got %b want %b", act_status(), exp_status());
      end
      tick();
    end
    @(negedge clk);
    drive(1'b0, 1'b0, '0);
    #1;
    vectors++;
    if (arReady !== 1'b0 || rdCount !== 4'd8) begin
      miscompares++;
      $display("FAIL full_flag: arReady=%b rdCount=%0d want 0 8", arReady, rdCount);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 4'b0100);
    #1;
    vectors++;
    if (act_data() !== exp_data()) begin
      miscompares++;
      $display("FAIL full_pop data: got %h want %h", act_data(), exp_data());
    end
    tick();
    @(negedge clk);
    drive(1'b0, 1'b0, '0);
    #1;
    vectors++;
    if (rdCount !== 4'd7 || arReady !== 1'b1) begin
      miscompares++;
      $display("FAIL full_refused_push: rdCount=%0d arReady=%b want 7 1", rdCount, arReady);
    end
    for (int i = 0; i < 12 && q_rd.size() != 0; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 4'b0010);
      #1;
      vectors++;
      if (act_data() !== exp_data()) begin
        miscompares++;
        $display("FAIL full_drain data: got %h want %h", act_data(), exp_data());
      end
      tick();
    end
  endtask

  task automatic test_watermark();
    bit seen_exit = 1'b0;
    bit was_drain = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i < 2)      drive(1'b1, 1'b0, '0);
      else if (i < 8) drive(1'b0, 1'b1, '0);
      else            drive(1'b0, 1'b0, 4'b1000);
      #1;
      vectors++;
      if (act_status() !== exp_status()) begin
        miscompares++;
        $display("FAIL watermark status cyc%0d: got %b want %b", i, act_status(), exp_status());
      end
      vectors++;
      if (act_data() !== exp_data()) begin
        miscompares++;
        $display("FAIL watermark data cyc%0d: got %h want %h", i, act_data(), exp_data());
      end
      if (was_drain && !drainMode && wrCount == 4'd2) seen_exit = 1'b1;
      was_drain = drainMode;
      tick();
    end
    vectors++;
    if (seen_exit !== 1'b1) begin
      miscompares++;
      $display("FAIL watermark_exit_at_low: seen=%b want 1", seen_exit);
    end
  endtask

  task automatic test_empty_switch();
    int wr_issues = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, i == 0, 4'b0001);
      #1;
      vectors++;
      if (act_status() !== exp_status()) begin
        miscompares++;
        $display("FAIL empty_switch status cyc%0d: got %b want %b", i, act_status(), exp_status());
      end
      if (issueValid && issueIsWrite) wr_issues++;
      tick();
    end
    vectors++;
    if (wr_issues != 1) begin
      miscompares++;
      $display("FAIL empty_switch_issue: write issues=%0d want 1", wr_issues);
    end
  endtask

  task automatic test_random();
    logic [NUM_FSM-1:0] t;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      t = ($urandom_range(0, 3) == 0) ? '0 : NUM_FSM'($urandom_range(1, 15));
      drive(1'($urandom), ($urandom_range(0, 2) == 0), t);
      #1;
      vectors++;
      if (act_status() !== exp_status()) begin
        miscompares++;
        $display("FAIL random status cyc%0d: got %b want %b", i, act_status(), exp_status());
      end
      vectors++;
      if (act_data() !== exp_data()) begin
        miscompares++;
        $display("FAIL random data cyc%0d: got %h want %h", i, act_data(), exp_data());
      end
      tick();
    end
    for (int i = 0; i < 40 && (q_rd.size() != 0 || q_wr.size() != 0); i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 4'b0001);
      tick();
    end
  endtask

`ifdef MEM_ARB_AGE_EN
  task automatic test_starvation();
    int wr_issue_cyc = -1;
    bit rd_after = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0)      drive(1'b1, 1'b0, '0);
      else if (i == 1) drive(1'b1, 1'b1, 4'b0001);
      else             drive(1'b1, 1'b0, 4'b0001);
      #1;
      vectors++;
      if (act_status() !== exp_status()) begin
        miscompares++;
        $display("FAIL starvation status cyc%0d: got %b want %b", i, act_status(), exp_status());
      end
      if (issueValid && issueIsWrite) wr_issue_cyc = i;
      if (wr_issue_cyc >= 0 && i > wr_issue_cyc && issueValid && !issueIsWrite) rd_after = 1'b1;
      tick();
    end
    vectors++;
    if (wr_issue_cyc != 2 + MAXA || rd_after !== 1'b1) begin
      miscompares++;
      $display("FAIL starvation_slot: write issued cyc%0d reads_resumed=%b want cyc%0d 1", wr_issue_cyc, rd_after, 2 + MAXA);
    end
    for (int i = 0; i < 20 && (q_rd.size() != 0 || q_wr.size() != 0); i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 4'b0001);
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_full();
    test_watermark();
    test_empty_switch();
`ifdef MEM_ARB_AGE_EN
    test_starvation();
`endif
    test_random();
    @(negedge clk);
    drive(1'b0, 1'b0, '0);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
